// File: rtl/hram_uart_cmd_if.sv
`default_nettype none
// ============================================================================
// Module : hram_uart_cmd_if
// Brief  : UART byte stream plus HyperRAM controller request/data bus.
// Rev    : 1.0  initial release
// ============================================================================
interface hram_uart_cmd_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        ctrl_rd_req;
  logic        ctrl_wr_req;
  logic [31:0] ctrl_addr;
  logic [31:0] ctrl_wr_d;
  logic [31:0] ctrl_rd_d;
  logic        ctrl_rd_rdy;
  logic        ctrl_busy;
  logic        rx_overrun;

  modport master (
    input  rx_valid, rx_data, tx_ready, ctrl_rd_d, ctrl_rd_rdy, ctrl_busy,
    output tx_start, tx_data, ctrl_rd_req, ctrl_wr_req, ctrl_addr, ctrl_wr_d,
           rx_overrun
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, ctrl_rd_d, ctrl_rd_rdy, ctrl_busy,
    input  tx_start, tx_data, ctrl_rd_req, ctrl_wr_req, ctrl_addr, ctrl_wr_d,
           rx_overrun
  );
endinterface
`default_nettype wire

// File: rtl/hram_uart_cmd.sv
`default_nettype none
// ============================================================================
// Module : hram_uart_cmd
// Brief  : 5-byte UART command frames to HyperRAM requests, 4-byte replies.
// Rev    : 1.0  initial release
// ============================================================================
module hram_uart_cmd #(
  parameter int unsigned FRAME_TIMEOUT = 1000000,
  parameter int unsigned RD_TIMEOUT    = 4096,
  parameter logic [31:0] ERR_WORD      = 32'hDEADBEEF
) (
  input  logic            clk,
  input  logic            rst,
  hram_uart_cmd_if.master bus
);

  localparam int unsigned c_GAP_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int unsigned c_RD_W  = $clog2(RD_TIMEOUT + 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(FRAME_TIMEOUT - 1);
  localparam logic [c_RD_W-1:0]  c_RD_LAST  = c_RD_W'(RD_TIMEOUT - 1);

  localparam logic [7:0] c_CMD_ADDR      = 8'h01;
  localparam logic [7:0] c_CMD_LOAD      = 8'h02;
  localparam logic [7:0] c_CMD_WRITE     = 8'h03;
  localparam logic [7:0] c_CMD_READ      = 8'h04;
  localparam logic [7:0] c_CMD_READ_REQ  = 8'h05;
  localparam logic [7:0] c_CMD_COUNT     = 8'h06;
  localparam logic [7:0] c_CMD_CONST     = 8'h07;
  localparam logic [7:0] c_CMD_READ_SYNC = 8'h08;

  localparam logic [2:0] S_RX        = 3'd0;
  localparam logic [2:0] S_EXEC      = 3'd1;
  localparam logic [2:0] S_WAIT_IDLE = 3'd2;
  localparam logic [2:0] S_WAIT_RD   = 3'd3;
  localparam logic [2:0] S_TX_SEND   = 3'd4;
  localparam logic [2:0] S_TX_WAIT   = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [39:0]        r_frame;
  logic [2:0]         r_byte_cnt;
  logic [c_GAP_W-1:0] r_gap;
  logic [c_RD_W-1:0]  r_rd_cnt;
  logic [31:0]        r_reply;
  logic [31:0]        r_rd_latch;
  logic [31:0]        r_count;
  logic [31:0]        r_addr;
  logic [31:0]        r_wr_d;
  logic [1:0]         r_tx_idx;
  logic [1:0]         r_tx_cnt;
  logic               r_seen_low;

  logic [7:0]  w_cmd;
  logic [31:0] w_data;
  logic        w_is_req;
  logic        w_tx_done;
  logic        w_tx_start;
  logic        w_wr_req;
  logic        w_rd_req;
  logic        w_overrun;

  assign w_cmd    = r_frame[39:32];
  assign w_data   = r_frame[31:0];
  assign w_is_req = (w_cmd == c_CMD_WRITE) || (w_cmd == c_CMD_READ_REQ) ||
                    (w_cmd == c_CMD_READ_SYNC);
  // A byte counts as sent on a low-then-high ready, or if ready never drops within 4 cycles.
  assign w_tx_done = r_seen_low ? bus.tx_ready : (bus.tx_ready && (r_tx_cnt == 2'd3));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RX;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RX:        if (bus.rx_valid && (r_byte_cnt == 3'd4)) w_next = S_EXEC;
      S_EXEC:      w_next = w_is_req ? S_WAIT_IDLE : S_TX_SEND;
      S_WAIT_IDLE: if (!bus.ctrl_busy)
                     w_next = (w_cmd == c_CMD_READ_SYNC) ? S_WAIT_RD : S_TX_SEND;
      S_WAIT_RD:   if (bus.ctrl_rd_rdy || (r_rd_cnt == c_RD_LAST)) w_next = S_TX_SEND;
      S_TX_SEND:   if (bus.tx_ready) w_next = S_TX_WAIT;
      S_TX_WAIT:   if (w_tx_done) w_next = (r_tx_idx == 2'd3) ? S_RX : S_TX_SEND;
      default:     w_next = S_RX;
    endcase
  end

  // Strobes are gated by rst so nothing escapes during the reset cycle itself.
  always_comb begin
    w_tx_start = 1'b0;
    w_wr_req   = 1'b0;
    w_rd_req   = 1'b0;
    w_overrun  = 1'b0;
    if (!rst) begin
      w_tx_start = (r_state == S_TX_SEND) && bus.tx_ready;
      w_wr_req   = (r_state == S_WAIT_IDLE) && !bus.ctrl_busy && (w_cmd == c_CMD_WRITE);
      w_rd_req   = (r_state == S_WAIT_IDLE) && !bus.ctrl_busy &&
                   ((w_cmd == c_CMD_READ_REQ) || (w_cmd == c_CMD_READ_SYNC));
      w_overrun  = bus.rx_valid && (r_state != S_RX);
    end
  end

  assign bus.tx_start    = w_tx_start;
  assign bus.tx_data     = r_reply[31:24];
  assign bus.ctrl_wr_req = w_wr_req;
  assign bus.ctrl_rd_req = w_rd_req;
  assign bus.ctrl_addr   = r_addr;
  assign bus.ctrl_wr_d   = r_wr_d;
  assign bus.rx_overrun  = w_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame    <= '0;
      r_byte_cnt <= '0;
      r_gap      <= '0;
      r_rd_cnt   <= '0;
      r_reply    <= '0;
      r_rd_latch <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_wr_d     <= '0;
      r_tx_idx   <= '0;
      r_tx_cnt   <= '0;
      r_seen_low <= 1'b0;
    end else begin
      if (bus.ctrl_rd_rdy) r_rd_latch <= bus.ctrl_rd_d;
      case (r_state)
        S_RX: begin
          if (bus.rx_valid) begin
            r_frame    <= {r_frame[31:0], bus.rx_data};
            r_gap      <= '0;
            r_byte_cnt <= (r_byte_cnt == 3'd4) ? 3'd0 : r_byte_cnt + 3'd1;
          end else if (r_byte_cnt != 3'd0) begin
            if (r_gap == c_GAP_LAST) begin
              r_byte_cnt <= '0;
              r_gap      <= '0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_tx_idx <= '0;
          case (w_cmd)
            c_CMD_ADDR:      begin r_addr <= w_data; r_reply <= w_data; end
            c_CMD_LOAD:      begin r_wr_d <= w_data; r_reply <= w_data; end
            c_CMD_WRITE:     r_reply <= 32'h3;
            c_CMD_READ:      r_reply <= r_rd_latch;
            c_CMD_READ_REQ:  r_reply <= 32'h5;
            c_CMD_COUNT:     begin r_reply <= r_count; r_count <= r_count + 32'd1; end
            c_CMD_CONST:     r_reply <= 32'd259;
            c_CMD_READ_SYNC: r_reply <= r_reply;
            default:         r_reply <= 32'hFFFF_FFFF;
          endcase
        end
        S_WAIT_IDLE: r_rd_cnt <= '0;
        S_WAIT_RD: begin
          if (bus.ctrl_rd_rdy)          r_reply  <= bus.ctrl_rd_d;
          else if (r_rd_cnt == c_RD_LAST) r_reply <= ERR_WORD;
          else                          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
        S_TX_SEND: begin
          r_tx_cnt   <= '0;
          r_seen_low <= 1'b0;
        end
        S_TX_WAIT: begin
          if (w_tx_done) begin
            r_reply  <= {r_reply[23:0], 8'h00};
            r_tx_idx <= r_tx_idx + 2'd1;
          end else if (!r_seen_low) begin
            if (!bus.tx_ready) r_seen_low <= 1'b1;
            else               r_tx_cnt   <= r_tx_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hram_uart_cmd.sv
`default_nettype none
// ============================================================================
// Module : tb_hram_uart_cmd
// Brief  : Directed + randomized frames checked against a command-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hram_uart_cmd;
  localparam int          FT  = 40;
  localparam int          RDT = 32;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hram_uart_cmd_if bus ();

  hram_uart_cmd #(.FRAME_TIMEOUT(FT), .RD_TIMEOUT(RDT), .ERR_WORD(ERR)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int tx_pulses = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] m_addr, m_wrd, m_count, m_latch;
  int          rd_delay_g = 0;
  logic [31:0] rd_val_g   = 32'h0;
  bit          rd_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_addr = 0; m_wrd = 0; m_count = 0; m_latch = 0;
  endtask

  // Command semantics as seen from the serial port; rdd=0 means the controller never answers.
  function automatic logic [31:0] model_exec(input logic [7:0] cmd, input logic [31:0] d,
                                             input int rdd, input logic [31:0] rdv);
    logic [31:0] r;
    case (cmd)
      8'h01: begin m_addr = d; r = d; end
      8'h02: begin m_wrd = d; r = d; end
      8'h03: r = 32'h3;
      8'h04: r = m_latch;
      8'h05: begin if (rdd > 0) m_latch = rdv; r = 32'h5; end
      8'h06: begin r = m_count; m_count = m_count + 1; end
      8'h07: r = 32'd259;
      8'h08: begin
        if (rdd > 0) begin m_latch = rdv; r = rdv; end
        else r = ERR;
      end
      default: r = 32'hFFFFFFFF;
    endcase
    return r;
  endfunction

  // Per-cycle checks on everything the bench can predict without knowing the FSM.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_start) begin
        tx_pulses++;
        if (exp_q.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL unexpected_tx: got tx byte %h, required no tx_start", bus.tx_data);
        end else begin
          chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          chk("addr_track", bus.ctrl_addr, m_addr);
          chk("wrd_track", bus.ctrl_wr_d, m_wrd);
        end
      end
      if (bus.ctrl_wr_req) begin
        wr_pulses++;
        chk("wr_req_while_busy", 32'(bus.ctrl_busy), 32'd0);
        chk("wr_req_addr", bus.ctrl_addr, m_addr);
        chk("wr_req_data", bus.ctrl_wr_d, m_wrd);
      end
      if (bus.ctrl_rd_req) begin
        rd_pulses++;
        chk("rd_req_while_busy", 32'(bus.ctrl_busy), 32'd0);
      end
      if (!bus.rx_valid) chk("overrun_without_byte", 32'(bus.rx_overrun), 32'd0);
    end
  end

  // uart_tx: ready falls 1-3 cycles after start and stays low 1-4 cycles, or never falls.
  initial begin : tx_model
    int mode;
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        mode = $urandom_range(0, 7);
        if (mode < 6) begin
          repeat (1 + mode % 3) @(posedge clk);
          #1 bus.tx_ready = 1'b0;
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1 bus.tx_ready = 1'b1;
        end
      end
    end
  end

  // Controller read path: answer a read request rd_delay_g cycles later with rd_val_g.
  initial begin : rd_model
    bus.ctrl_rd_rdy = 1'b0;
    bus.ctrl_rd_d   = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && bus.ctrl_rd_req && rd_delay_g > 0) begin
        rd_pending = 1'b1;
        repeat (rd_delay_g) @(posedge clk);
        #1 bus.ctrl_rd_rdy = 1'b1; bus.ctrl_rd_d = rd_val_g;
        @(posedge clk);
        #1 bus.ctrl_rd_rdy = 1'b0; bus.ctrl_rd_d = $urandom();
        rd_pending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic exp_ovr);
    @(posedge clk);
    #1 bus.rx_valid = 1'b1; bus.rx_data = b;
    @(negedge clk);
    chk(exp_ovr ? "overrun_pulse" : "overrun_quiet", 32'(bus.rx_overrun), 32'(exp_ovr));
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_wr_req"}, 32'(bus.ctrl_wr_req), 32'd0);
    chk({tag, "_rd_req"}, 32'(bus.ctrl_rd_req), 32'd0);
    chk({tag, "_addr"}, bus.ctrl_addr, 32'd0);
    chk({tag, "_wr_d"}, bus.ctrl_wr_d, 32'd0);
    chk({tag, "_overrun"}, 32'(bus.rx_overrun), 32'd0);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b0);
    idle(FT + 5);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data,
                            input logic [31:0] exp, input int busy, input int rdd,
                            input logic [31:0] rdv, input bit extra);
    int w0, r0, t0, cyc;
    logic [39:0] fr;
    rd_delay_g = rdd;
    rd_val_g   = rdv;
    for (int i = 3; i >= 0; i--) exp_q.push_back(exp[i*8 +: 8]);
    w0 = wr_pulses; r0 = rd_pulses; t0 = tx_pulses;
    fr = {cmd, data};
    for (int i = 4; i >= 0; i--) begin
      send_byte(fr[i*8 +: 8], 1'b0);
      if (i == 0) bus.ctrl_busy = (busy > 0);
      else if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 4));
    end
    idle(0);
    if (busy > 0) begin
      repeat (busy - 1) @(posedge clk);
      #1 bus.ctrl_busy = 1'b0;
    end
    cyc = 0;
    if (extra) begin
      while (exp_q.size() > 3 && cyc < 2000) begin @(negedge clk); cyc++; end
      send_byte(8'($urandom), 1'b1);
      idle(0);
    end
    while (exp_q.size() > 0 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("reply_bytes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    while ((rd_pending || !bus.tx_ready) && cyc < 4000) begin @(negedge clk); cyc++; end
    repeat (8) @(posedge clk);
    chk("tx_start_pulses", 32'(tx_pulses - t0), 32'd4);
    chk("wr_req_pulses", 32'(wr_pulses - w0), 32'(cmd == 8'h03));
    chk("rd_req_pulses", 32'(rd_pulses - r0), 32'(cmd == 8'h05 || cmd == 8'h08));
  endtask

  initial begin : main
    logic [7:0]  cmd;
    logic [31:0] d, rv, e;
    int          rdd, bsy, cyc;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h0;
    bus.ctrl_busy = 1'b0;
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    chk_reset_outputs("in_reset");
    @(posedge clk); #1 rst = 1'b0;
    chk_reset_outputs("after_reset");

    // Directed frames with hand-computed replies.
    void'(model_exec(8'h01, 32'h00001000, 0, 0));
    send_frame(8'h01, 32'h00001000, 32'h00001000, 0, 0, 0, 1'b0);
    chk("addr_literal", bus.ctrl_addr, 32'h00001000);
    void'(model_exec(8'h02, 32'h12345678, 0, 0));
    send_frame(8'h02, 32'h12345678, 32'h12345678, 0, 0, 0, 1'b0);
    void'(model_exec(8'h03, 32'h0, 0, 0));
    send_frame(8'h03, 32'h0, 32'h00000003, 10, 0, 0, 1'b0);
    chk("wr_d_literal", bus.ctrl_wr_d, 32'h12345678);
    void'(model_exec(8'h08, 32'h0, 20, 32'hCAFEF00D));
    send_frame(8'h08, 32'h0, 32'hCAFEF00D, 0, 20, 32'hCAFEF00D, 1'b0);
    void'(model_exec(8'h04, 32'h0, 0, 0));
    send_frame(8'h04, 32'h0, 32'hCAFEF00D, 0, 0, 0, 1'b0);
    void'(model_exec(8'h08, 32'h0, 0, 0));
    send_frame(8'h08, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    void'(model_exec(8'h07, 32'h0, 0, 0));
    send_frame(8'h07, 32'h0, 32'h00000103, 0, 0, 0, 1'b0);
    send_partial(3);
    void'(model_exec(8'h06, 32'h0, 0, 0));
    send_frame(8'h06, 32'h0, 32'h00000000, 0, 0, 0, 1'b0);
    void'(model_exec(8'h06, 32'h0, 0, 0));
    send_frame(8'h06, 32'h0, 32'h00000001, 0, 0, 0, 1'b1);

    // Randomized frames against the model.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 8) cmd = 8'($urandom_range(1, 8));
      else cmd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(9, 255));
      d   = $urandom();
      rv  = $urandom();
      bsy = $urandom_range(0, 6);
      rdd = 0;
      if (cmd == 8'h05 || cmd == 8'h08)
        rdd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      if ($urandom_range(0, 5) == 0) send_partial($urandom_range(1, 4));
      e = model_exec(cmd, d, rdd, rv);
      send_frame(cmd, d, e, bsy, rdd, rv, $urandom_range(0, 4) == 0);
    end

    // Reset while the second reply byte is in flight.
    rd_delay_g = 0;
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(32'h00000103 >> (i * 8)));
    send_byte(8'h07, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
    idle(0);
    cyc = 0;
    while (exp_q.size() > 2 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("reset_test_two_bytes_sent", 32'(exp_q.size()), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_reset_outputs("mid_reply_reset");
    void'(model_exec(8'h07, 32'h0, 0, 0));
    send_frame(8'h07, 32'h0, 32'h00000103, 0, 0, 0, 1'b0);
    void'(model_exec(8'h06, 32'h0, 0, 0));
    send_frame(8'h06, 32'h0, 32'h00000000, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hram_uart_cmd.md
Name: hram_uart_cmd

Overview:
- Serial command engine between uart_rx/uart_tx and hyperram_controller.
- Assembles 5-byte command frames from the UART receiver and drives the controller's request/address/data inputs.
- Latches read data and returns exactly 4 reply bytes, MSB first, per frame.
- Sits directly upstream of hyperram_controller; replaces the ad-hoc serial logic in the top level.

Parameters:
- FRAME_TIMEOUT, 1000000: idle cycles between received bytes before a partial frame is discarded.
- RD_TIMEOUT, 4096: cycles READ_SYNC waits for ctrl_rd_rdy before replying with the error word.
- ERR_WORD, 32'hDEADBEEF: reply word on read timeout.

Ports:
- clk  in  1  system clock (hram_clk domain).
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe from uart_rx; byte is on rx_data.
- rx_data  in  8  received byte.
- tx_ready  in  1  uart_tx idle.
- tx_start  out  1  one-cycle start strobe to uart_tx.
- tx_data  out  8  byte to transmit; valid while tx_start=1.
- ctrl_rd_req  out  1  one-cycle read request.
- ctrl_wr_req  out  1  one-cycle write request.
- ctrl_addr  out  32  controller address.
- ctrl_wr_d  out  32  controller write data.
- ctrl_rd_d  in  32  controller read data.
- ctrl_rd_rdy  in  1  read data valid strobe.
- ctrl_busy  in  1  controller busy.
- rx_overrun  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, ctrl_addr=0, ctrl_wr_d=0, rd_latch=0, count=0, byte counter=0, state=RX. Reset mid-frame or mid-reply abandons it; no further tx_start is issued.
- Frame format: byte0 = cmd, bytes1..4 = 32-bit data, MSB first. No trailing byte.
- rd_latch loads ctrl_rd_d on every ctrl_rd_rdy, in any state.
- States: RX, EXEC, WAIT_IDLE, WAIT_RD, TX_SEND, TX_WAIT.
- RX:
  - Shift in each rx_valid byte.
  - Gap counter resets on each byte; it reaching FRAME_TIMEOUT with 1-4 bytes held clears the byte count.
  - On the 5th byte (cycle N), go to EXEC at N+1.
- EXEC, by cmd:
  - 0x01 ADDR: ctrl_addr<=data; reply=data.
  - 0x02 LOAD: ctrl_wr_d<=data; reply=data.
  - 0x03 WRITE: go to WAIT_IDLE; reply=32'h3.
  - 0x04 READ: reply=rd_latch.
  - 0x05 READ_REQ: go to WAIT_IDLE; reply=32'h5.
  - 0x06 COUNT: reply=count; count<=count+1 (wraps at 2^32).
  - 0x07 CONST: reply=32'd259.
  - 0x08 READ_SYNC: go to WAIT_IDLE, then WAIT_RD.
  - Any other cmd: reply=32'hFFFFFFFF.
  - Non-request commands go to TX_SEND at N+2.
- WAIT_IDLE:
  - When ctrl_busy=0, pulse the matching req for exactly one cycle.
  - WRITE/READ_REQ then go to TX_SEND; READ_SYNC goes to WAIT_RD.
  - A req is never asserted while ctrl_busy=1.
- WAIT_RD:
  - On ctrl_rd_rdy: reply=ctrl_rd_d, go to TX_SEND.
  - After RD_TIMEOUT cycles without it: reply=ERR_WORD, go to TX_SEND.
- TX_SEND: when tx_ready=1, assert tx_start for one cycle with tx_data=reply[31:24], then go to TX_WAIT.
- TX_WAIT:
  - Wait for tx_ready to fall and then rise; a ready that falls 1-2 cycles late is tolerated.
  - Then shift reply left 8 bits. After 4 bytes return to RX, else go to TX_SEND.
  - A tx_ready that never falls within 4 cycles counts as a sent byte.
- Bytes arriving outside RX are dropped and pulse rx_overrun in the same cycle.
- An rx_valid in the same cycle as the transition out of TX_WAIT into RX is dropped.

Test Plan:
- Reset, then frame 01 00 00 10 00 -> ctrl_addr=32'h00001000; tx bytes 00 00 10 00; exactly 4 tx_start pulses.
- Frames LOAD 12345678, then WRITE with ctrl_busy high for 10 cycles -> ctrl_wr_req single pulse only after busy falls; ctrl_wr_d=12345678; reply 00 00 00 03.
- READ_SYNC with ctrl_rd_rdy/ctrl_rd_d=CAFEF00D 20 cycles after req -> reply CA FE F0 0D; then READ -> CA FE F0 0D.
- READ_SYNC with no ctrl_rd_rdy -> reply DE AD BE EF after RD_TIMEOUT; next frame processed normally.
- Send 3 bytes, idle FRAME_TIMEOUT cycles, then full COUNT frame twice -> replies 00000000 then 00000001; extra byte sent during reply -> rx_overrun pulse.
- Assert rst during the 2nd reply byte -> tx_start stays 0, outputs at reset values; CONST frame afterwards -> 00 00 01 03.
